fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the 8-bit CPU.
- Owns the program counter and drives the address of the combinational instruction ROM.
- Registers the returned byte into an instruction register (IR) with a valid/ready handshake to the decode stage.
- Supports redirect (jump/branch) with flush, and halt/resume under decoder control.

Parameters:
- AW, 8, PC / ROM address width.
- DW, 8, instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- addr  output  AW  ROM address; always equals the current PC register (no combinational path from inputs).
- instr  input  DW  ROM data for addr, valid in the same cycle.
- ir  output  DW  fetched instruction presented to decode.
- ir_pc  output  AW  address the instruction in ir was fetched from.
- ir_valid  output  1  ir/ir_pc hold a valid instruction.
- ir_ready  input  1  decode accepts ir this cycle.
- redirect  input  1  load redirect_pc into PC and flush IR.
- redirect_pc  input  AW  redirect target.
- halt  input  1  stop fetching.
- halted  output  1  fetch is in HALT state.

Behaviour:
- Reset (async, immediate on rst_n low):
  - pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, state=RUN, halted=0.
  - First fetch occurs on the first rising edge after release, so ir_valid=1 in the following cycle.
- States:
  - RUN: fetching.
  - HALT: no fetches; halted=1.
- slot_free = !ir_valid | ir_ready.
- RUN, no redirect/halt, slot_free:
  - ir<=instr, ir_pc<=pc, ir_valid<=1, pc<=pc+1.
  - Sustains 1 instruction/cycle.
- RUN, ir_valid=1 & ir_ready=0 (stall): ir, ir_pc, ir_valid and pc all hold.
- Wrap-around: pc+1 is modulo 2^AW (255 -> 0); fetch continues without a gap.
- redirect=1 (any state, stalled or not):
  - pc<=redirect_pc, ir_valid<=0; ir and ir_pc hold stale values.
  - No IR load that cycle; a concurrent ir_ready handshake is discarded.
  - Latency: redirect in cycle N -> addr=target in N+1 -> ir_valid=1 with ir_pc=target in N+2.
  - redirect in HALT resumes fetch: state<=RUN.
- halt=1 in RUN, no redirect:
  - state<=HALT; no IR load that cycle; pc holds.
  - An IR already valid remains valid until handshaked, then ir_valid<=0.
- halt=1 and redirect=1 in the same cycle:
  - pc<=redirect_pc, IR flushed, state<=HALT.
  - Resume only by a later redirect.
- HALT:
  - pc and addr static; halt is ignored.
  - Leaves only via redirect or reset.
- Reset mid-stall or mid-redirect: all state returns to reset values immediately; pending handshake is lost.
- Outputs are registered except addr, which is the pc register itself.

Optional Feature:
- Macro FETCH_CNT_EN.
- Defined:
  - Adds output port fetch_cnt, 16 bits.
  - Counts completed ir handshakes (ir_valid & ir_ready & !redirect).
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst_n.
  - Cleared by neither redirect nor halt.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- ROM[i]=i^8'hA5, ir_ready=1, release reset with RESET_PC=0 -> cycle 1 after the first edge: ir=A5, ir_pc=00; next cycles ir=A4/A7/A6 with ir_pc incrementing every cycle.
- ir_ready=0 for 3 cycles while ir_pc=05 -> ir=A0 and ir_pc=05 held; pc held at 06; on ir_ready=1, the next cycle shows ir_pc=06.
- RESET_PC=8'hFE, ir_ready=1 -> ir_pc sequence FE, FF, 00, 01 with no bubble.
- redirect=1, redirect_pc=40 while ir_valid=1 and stalled -> next cycle ir_valid=0, addr=40; the following cycle ir=E5, ir_pc=40.
- halt=1 at ir_pc=10 with ir_ready=0 -> halted=1, IR at 10 held until ir_ready=1, then ir_valid=0 permanently; redirect_pc=20 then resumes at 20.
- halt and redirect (redirect_pc=30) in the same cycle -> halted=1, ir_valid=0, addr=30; with FETCH_CNT_EN, fetch_cnt equals the number of handshakes before the event, and drop rst_n mid-run -> all outputs zero immediately.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the 8-bit CPU.
// Owns the PC, drives the combinational ROM address, and registers the
// returned byte into an IR with a valid/ready handshake to decode.
// Supports redirect with flush, and halt/resume under decoder control.
// Optional build macro: FETCH_CNT_EN adds a saturating 16-bit count of
// completed IR handshakes on output port fetch_cnt.
module fetch_unit #(
  parameter int            AW       = 8,
  parameter int            DW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] addr,
  input  logic [DW-1:0] instr,
  output logic [DW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt,
  output logic          halted
`ifdef FETCH_CNT_EN
  ,
  output logic [15:0]   fetch_cnt
`endif
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] pc_reg, pc_next;
  logic [DW-1:0] ir_reg, ir_next;
  logic [AW-1:0] ir_pc_reg, ir_pc_next;
  logic          valid_reg, valid_next;
  logic          handshake;
  logic          slot_free;

  assign handshake = valid_reg & ir_ready;
  assign slot_free = ~valid_reg | ir_ready;

  // State and datapath registers; everything clears immediately on rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_RUN;
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
      ir_pc_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      ir_pc_reg <= ir_pc_next;
      valid_reg <= valid_next;
    end
  end

  // Next-state logic: redirect wins over everything, then halt, then fetch.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    ir_pc_next = ir_pc_reg;
    valid_next = valid_reg;
    if (redirect) begin
      // Flush: ir/ir_pc keep stale contents, any concurrent handshake is dropped.
      pc_next    = redirect_pc;
      valid_next = 1'b0;
      // In RUN a simultaneous halt parks at the target; in HALT halt is ignored.
      state_next = (state_reg == S_RUN && halt) ? S_HALT : S_RUN;
    end else begin
      unique case (state_reg)
        S_RUN: begin
          if (halt) begin
            state_next = S_HALT;
            if (handshake) valid_next = 1'b0;
          end else if (slot_free) begin
            ir_next    = instr;
            ir_pc_next = pc_reg;
            valid_next = 1'b1;
            pc_next    = pc_reg + AW'(1);
          end
        end
        S_HALT: begin
          // No fetching; a held instruction drains once decode takes it.
          if (handshake) valid_next = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign addr     = pc_reg;
  assign ir       = ir_reg;
  assign ir_pc    = ir_pc_reg;
  assign ir_valid = valid_reg;
  assign halted   = (state_reg == S_HALT);

`ifdef FETCH_CNT_EN
  logic [15:0] cnt_reg;

  // Saturating count of instructions accepted by decode; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (handshake && !redirect && cnt_reg != 16'hFFFF) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign fetch_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a
// transaction-level reference model. ROM contents are addr ^ 8'hA5.
module tb_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] addr;
  logic [7:0] instr;
  logic [7:0] ir;
  logic [7:0] ir_pc;
  logic       ir_valid;
  logic       ir_ready;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       halt;
  logic       halted;
`ifdef FETCH_CNT_EN
  logic [15:0] fetch_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_pc, m_ir, m_ir_pc;
  logic       m_valid, m_halt;
  int         m_cnt;

  fetch_unit #(.AW(8), .DW(8), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr        (addr),
    .instr       (instr),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .halted      (halted)
`ifdef FETCH_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt)
`endif
  );

  // Combinational ROM
  assign instr = addr ^ 8'hA5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_ir = 8'h00; m_ir_pc = 8'h00;
    m_valid = 1'b0; m_halt = 1'b0; m_cnt = 0;
  endtask

  task automatic compare_all();
    check("addr", 32'(addr), 32'(m_pc));
    check("ir", 32'(ir), 32'(m_ir));
    check("ir_pc", 32'(ir_pc), 32'(m_ir_pc));
    check("ir_valid", 32'(ir_valid), 32'(m_valid));
    check("halted", 32'(halted), 32'(m_halt));
`ifdef FETCH_CNT_EN
    check("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
`endif
  endtask

  // One clock: apply inputs, advance model by the fetch rules, compare.
  task automatic cyc(input logic rdy, input logic rd, input logic [7:0] rpc, input logic hl);
    logic taken;
    ir_ready = rdy; redirect = rd; redirect_pc = rpc; halt = hl;
    @(posedge clk);
    taken = m_valid && rdy;
    if (taken && !rd && m_cnt < 65535) m_cnt++;
    if (rd) begin
      m_pc    = rpc;
      m_valid = 1'b0;
      m_halt  = m_halt ? 1'b0 : hl;
    end else if (m_halt || hl) begin
      m_halt = 1'b1;
      if (taken) m_valid = 1'b0;
    end else if (!m_valid || rdy) begin
      m_ir    = m_pc ^ 8'hA5;
      m_ir_pc = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 8'd1;
    end
    #1;
    compare_all();
    $display("cyc t=%0t rdy=%0b rd=%0b rpc=%02h hl=%0b -> addr=%02h ir=%02h ir_pc=%02h v=%0b h=%0b",
             $time, rdy, rd, rpc, hl, addr, ir, ir_pc, ir_valid, halted);
  endtask

  initial begin
    rst_n = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; halt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // Streaming from RESET_PC
    cyc(1, 0, 8'h00, 0);
    check("first_ir", 32'(ir), 32'h A5);
    check("first_ir_pc", 32'(ir_pc), 32'h00);
    cyc(1, 0, 8'h00, 0); check("seq_ir1", 32'(ir), 32'hA4);
    cyc(1, 0, 8'h00, 0); check("seq_ir2", 32'(ir), 32'hA7);
    cyc(1, 0, 8'h00, 0); check("seq_ir3", 32'(ir), 32'hA6);

    // Stall while ir_pc = 05
    for (int i = 0; i < 10 && m_ir_pc != 8'h05; i++) cyc(1, 0, 8'h00, 0);
    check("reach_05", 32'(ir_pc), 32'h05);
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 0);
    check("stall_ir", 32'(ir), 32'hA0);
    check("stall_pc", 32'(addr), 32'h06);
    cyc(1, 0, 8'h00, 0);
    check("unstall_ir_pc", 32'(ir_pc), 32'h06);

    // Wrap-around without a bubble
    cyc(1, 1, 8'hFE, 0);
    cyc(1, 0, 8'h00, 0); check("wrap0", 32'(ir_pc), 32'hFE);
    cyc(1, 0, 8'h00, 0); check("wrap1", 32'(ir_pc), 32'hFF);
    cyc(1, 0, 8'h00, 0); check("wrap2", 32'(ir_pc), 32'h00);
    cyc(1, 0, 8'h00, 0); check("wrap3", 32'(ir_pc), 32'h01);

    // Redirect while stalled
    cyc(0, 0, 8'h00, 0);
    cyc(0, 1, 8'h40, 0);
    check("redir_valid", 32'(ir_valid), 32'h0);
    check("redir_addr", 32'(addr), 32'h40);
    cyc(1, 0, 8'h00, 0);
    check("redir_ir", 32'(ir), 32'hE5);
    check("redir_ir_pc", 32'(ir_pc), 32'h40);

    // Halt with a stalled instruction at 10
    cyc(1, 1, 8'h10, 0);
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 1);
    check("halt_h", 32'(halted), 32'h1);
    check("halt_hold", 32'(ir_pc), 32'h10);
    cyc(0, 0, 8'h00, 0);
    check("halt_valid_held", 32'(ir_valid), 32'h1);
    cyc(1, 0, 8'h00, 0);
    check("halt_drain", 32'(ir_valid), 32'h0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'h00, i[0]);
    check("halt_stays", 32'(ir_valid), 32'h0);
    check("halt_addr", 32'(addr), 32'h11);
    cyc(1, 1, 8'h20, 0);
    check("resume_h", 32'(halted), 32'h0);
    cyc(1, 0, 8'h00, 0);
    check("resume_ir_pc", 32'(ir_pc), 32'h20);

    // Halt and redirect together
    cyc(1, 1, 8'h30, 1);
    check("hr_h", 32'(halted), 32'h1);
    check("hr_valid", 32'(ir_valid), 32'h0);
    check("hr_addr", 32'(addr), 32'h30);
    cyc(1, 1, 8'h50, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(logic'($urandom_range(0, 9) < 7),
          logic'($urandom_range(0, 9) == 0),
          8'($urandom),
          logic'($urandom_range(0, 11) == 0));
    end

    // Asynchronous reset in the middle of a stall
    cyc(1, 1, 8'h77, 0);
    cyc(1, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_ir", 32'(ir), 32'h0);
    #20;
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
